// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared opcode/state enums and instruction field decode for regfile_copy_hs
package regfile_pkg;

    typedef enum logic [1:0] {
        OP_COPY    = 2'b00,
        OP_SWAP    = 2'b01,
        OP_CLEAR   = 2'b10,
        OP_ILLEGAL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_IN,
        S_WAIT_OUT
    } state_e;

    localparam int MAX_IDX_W  = 8;
    localparam int INST_MAX_W = 2 + 2 * MAX_IDX_W;

    typedef struct packed {
        op_e                  op;
        logic [MAX_IDX_W-1:0] src;
        logic [MAX_IDX_W-1:0] dst;
    } inst_fields_t;

    // Fields are returned zero-extended to MAX_IDX_W so callers can range-check the full value.
    function automatic inst_fields_t decode_inst(input logic [INST_MAX_W-1:0] inst, input int idx_w);
        inst_fields_t            f;
        logic [INST_MAX_W-1:0]   mask;
        mask  = INST_MAX_W'((1 << idx_w) - 1);
        f.dst = MAX_IDX_W'(inst & mask);
        f.src = MAX_IDX_W'((inst >> idx_w) & mask);
        f.op  = op_e'(2'(inst >> (2 * idx_w)));
        return f;
    endfunction

endpackage

// File: rtl/regfile_copy_hs_if.sv
// rtl/regfile_copy_hs_if.sv - instruction/input/output handshakes and register visibility bundle
interface regfile_copy_hs_if #(
    parameter int WIDTH    = 8,
    parameter int NUM_REGS = 6
);
    localparam int IDX_W  = $clog2(NUM_REGS + 1);
    localparam int INST_W = 2 + 2 * IDX_W;

    logic                      inst_valid;
    logic                      inst_ready;
    logic [INST_W-1:0]         inst;
    logic [WIDTH-1:0]          in_data;
    logic                      in_valid;
    logic                      in_ready;
    logic [WIDTH-1:0]          out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [NUM_REGS*WIDTH-1:0] regs_flat;
    logic                      busy;
    logic                      err;

    modport master (
        output inst_valid, inst, in_data, in_valid, out_ready,
        input  inst_ready, in_ready, out_data, out_valid, regs_flat, busy, err
    );

    modport slave (
        input  inst_valid, inst, in_data, in_valid, out_ready,
        output inst_ready, in_ready, out_data, out_valid, regs_flat, busy, err
    );

endinterface

// File: rtl/regfile_io_ctrl.sv
// rtl/regfile_io_ctrl.sv - IDLE/WAIT_IN/WAIT_OUT handshake sequencer for regfile_copy_hs
module regfile_io_ctrl
    import regfile_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start_in,
    input  logic start_out,
    input  logic in_valid,
    input  logic in_to_out,
    input  logic out_ready,
    output logic inst_ready,
    output logic in_ready,
    output logic out_valid,
    output logic busy
);

    state_e state_q;
    state_e state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    state_d = S_WAIT_IN;
                end else if (start_out) begin
                    state_d = S_WAIT_OUT;
                end
            end
            S_WAIT_IN: begin
                if (in_valid) begin
                    state_d = in_to_out ? S_WAIT_OUT : S_IDLE;
                end
            end
            S_WAIT_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs depend on state only, so accept logic upstream never loops back into itself.
    assign inst_ready = (state_q == S_IDLE);
    assign in_ready   = (state_q == S_WAIT_IN);
    assign out_valid  = (state_q == S_WAIT_OUT);
    assign busy       = (state_q != S_IDLE);

endmodule

// File: rtl/regfile_copy_hs.sv
// rtl/regfile_copy_hs.sv - register file with COPY/SWAP/CLEAR and handshaked I/O port
// REGFILE_ZERO_REG_EN: when defined, register 0 is hard-wired to zero.
module regfile_copy_hs
    import regfile_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int NUM_REGS = 6
) (
    input  logic             clk,
    input  logic             rst,
    regfile_copy_hs_if.slave bus
);

    localparam int              IDX_W  = $clog2(NUM_REGS + 1);
    localparam logic [IDX_W-1:0] IO_IDX = IDX_W'(NUM_REGS);

    logic [WIDTH-1:0] regs [NUM_REGS];
    logic [WIDTH-1:0] out_data_q;
    logic [IDX_W-1:0] pend_dst_q;
    logic             err_q;

    inst_fields_t     fields;
    op_e              op;
    logic [IDX_W-1:0] src;
    logic [IDX_W-1:0] dst;
    logic             src_is_io;
    logic             dst_is_io;
    logic             illegal;
    logic             accept;
    logic             start_in;
    logic             start_out;
    logic             reg_op;
    logic             in_fire;
    logic             pend_is_io;

    logic inst_ready;
    logic in_ready;
    logic out_valid;
    logic busy;

    always_comb begin
        fields    = decode_inst(INST_MAX_W'(bus.inst), IDX_W);
        op        = fields.op;
        src       = IDX_W'(fields.src);
        dst       = IDX_W'(fields.dst);
        src_is_io = (src == IO_IDX);
        dst_is_io = (dst == IO_IDX);
        illegal   = (op == OP_ILLEGAL)
                 || (fields.src > MAX_IDX_W'(NUM_REGS))
                 || (fields.dst > MAX_IDX_W'(NUM_REGS))
                 || ((op == OP_SWAP) && (src_is_io || dst_is_io));
        accept    = bus.inst_valid && inst_ready;
        start_in  = accept && !illegal && (op == OP_COPY) && src_is_io;
        start_out = accept && !illegal && dst_is_io
                 && (((op == OP_COPY) && !src_is_io) || (op == OP_CLEAR));
        reg_op    = accept && !illegal && !dst_is_io && !((op == OP_COPY) && src_is_io);
    end

    assign in_fire    = bus.in_valid && in_ready;
    assign pend_is_io = (pend_dst_q == IO_IDX);

    regfile_io_ctrl u_io_ctrl (
        .clk        (clk),
        .rst        (rst),
        .start_in   (start_in),
        .start_out  (start_out),
        .in_valid   (bus.in_valid),
        .in_to_out  (pend_is_io),
        .out_ready  (bus.out_ready),
        .inst_ready (inst_ready),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .busy       (busy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            out_data_q <= '0;
            pend_dst_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (accept && illegal) begin
                err_q <= 1'b1;
            end
            if (reg_op) begin
                case (op)
                    OP_COPY:  regs[dst] <= regs[src];
                    OP_SWAP: begin
                        regs[dst] <= regs[src];
                        regs[src] <= regs[dst];
                    end
                    OP_CLEAR: regs[dst] <= '0;
                    default: ;
                endcase
            end
            if (start_in) begin
                pend_dst_q <= dst;
            end
            if (start_out) begin
                out_data_q <= (op == OP_CLEAR) ? '0 : regs[src];
            end
            if (in_fire) begin
                if (pend_is_io) begin
                    out_data_q <= bus.in_data;
                end else begin
                    regs[pend_dst_q] <= bus.in_data;
                end
            end
`ifdef REGFILE_ZERO_REG_EN
            // Last assignment wins, so every write to register 0 is discarded.
            regs[0] <= '0;
`else
`endif
        end
    end

    always_comb begin
        bus.regs_flat = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            bus.regs_flat[i*WIDTH +: WIDTH] = regs[i];
        end
    end

    assign bus.inst_ready = inst_ready;
    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.out_data   = out_data_q;
    assign bus.busy       = busy;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_regfile_copy_hs.sv
// tb/tb_regfile_copy_hs.sv - table-driven, directed and randomized checks of regfile_copy_hs
module tb_regfile_copy_hs;

    localparam int W = 8;
    localparam int N = 6;
`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO = 1'b1;
`else
    localparam bit ZERO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_copy_hs_if #(.WIDTH(W), .NUM_REGS(N)) bus ();
    regfile_copy_hs #(.WIDTH(W), .NUM_REGS(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_errs   = 0;

    logic [7:0] m_regs [N];
    logic       m_err;

    typedef struct {
        logic [1:0] op;
        logic [2:0] src;
        logic [2:0] dst;
        logic [7:0] in_val;
        int         in_dly;
        int         out_dly;
        int         ia;
        logic [7:0] va;
        int         ib;
        logic [7:0] vb;
        logic [7:0] exp_out;
        logic       exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic is_illegal(input logic [1:0] op, input logic [2:0] s, input logic [2:0] d);
        return (op == 2'd3) || (s > 3'd6) || (d > 3'd6) || ((op == 2'd1) && ((s == 3'd6) || (d == 3'd6)));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_regs[i] = 8'h00;
        m_err = 1'b0;
    endtask

    function automatic logic [47:0] model_flat();
        logic [47:0] f;
        for (int i = 0; i < N; i++) f[i*8 +: 8] = m_regs[i];
        return f;
    endfunction

    // Architectural effect of one whole instruction, I/O value included.
    task automatic model_apply(input logic [1:0] op, input logic [2:0] s, input logic [2:0] d,
                               input logic [7:0] in_val, output logic [7:0] out_val);
        logic [7:0] t;
        out_val = 8'h00;
        if (is_illegal(op, s, d)) begin
            m_err = 1'b1;
            return;
        end
        case (op)
            2'd0: begin
                t = (s == 3'd6) ? in_val : m_regs[s];
                if (d == 3'd6) out_val = t;
                else m_regs[d] = t;
            end
            2'd1: begin
                t         = m_regs[s];
                m_regs[s] = m_regs[d];
                m_regs[d] = t;
            end
            default: if (d != 3'd6) m_regs[d] = 8'h00;
        endcase
        if (ZERO) m_regs[0] = 8'h00;
    endtask

    task automatic exec(input logic [1:0] op, input logic [2:0] s, input logic [2:0] d,
                        input logic [7:0] in_val, input int in_dly, input int out_dly,
                        output logic [7:0] got_out);
        logic       ill, need_in, need_out;
        logic [7:0] exp_out;
        ill      = is_illegal(op, s, d);
        need_in  = !ill && (op == 2'd0) && (s == 3'd6);
        need_out = !ill && (d == 3'd6);
        got_out  = 8'h00;
        chk("inst_ready_idle", bus.inst_ready, 1);
        bus.inst_valid = 1'b1;
        bus.inst       = {op, s, d};
        bus.in_valid   = 1'($urandom_range(0, 1));
        bus.in_data    = 8'($urandom);
        bus.out_ready  = 1'($urandom_range(0, 1));
        tick();
        bus.inst_valid = 1'b0;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        model_apply(op, s, d, in_val, exp_out);
        if (need_in) begin
            for (int i = 0; i < in_dly; i++) begin
                chk("wait_in_ready", bus.in_ready, 1);
                chk("wait_in_busy", bus.busy, 1);
                chk("wait_in_inst_ready", bus.inst_ready, 0);
                bus.in_data = 8'($urandom);
                tick();
            end
            chk("in_ready_before_data", bus.in_ready, 1);
            bus.in_valid = 1'b1;
            bus.in_data  = in_val;
            tick();
            bus.in_valid = 1'b0;
        end else begin
            chk("in_ready_low", bus.in_ready, 0);
        end
        if (need_out) begin
            for (int i = 0; i < out_dly; i++) begin
                chk("out_valid_hold", bus.out_valid, 1);
                chk("out_data_hold", bus.out_data, exp_out);
                chk("out_inst_ready", bus.inst_ready, 0);
                tick();
            end
            chk("out_valid", bus.out_valid, 1);
            chk("out_data", bus.out_data, exp_out);
            got_out       = bus.out_data;
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
            chk("out_valid_cleared", bus.out_valid, 0);
        end
        chk("busy_done", bus.busy, 0);
        chk("err_model", bus.err, m_err);
        chk("regs_model", bus.regs_flat, model_flat());
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [2:0] s, input logic [2:0] d,
                                input logic [7:0] iv, input int idl, input int odl,
                                input int ia, input logic [7:0] va, input int ib, input logic [7:0] vb,
                                input logic [7:0] eo, input logic ee);
        vec_t v;
        v.op = op; v.src = s; v.dst = d; v.in_val = iv; v.in_dly = idl; v.out_dly = odl;
        v.ia = ia; v.va = va; v.ib = ib; v.vb = vb; v.exp_out = eo; v.exp_err = ee;
        return v;
    endfunction

    initial begin
        logic [7:0] got;
        logic [7:0] dummy;
        logic [1:0] rop;
        int         r;

        bus.inst_valid = 1'b0;
        bus.inst       = '0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b0;
        model_reset();

        vecs.push_back(mk(2'd0, 3'd6, 3'd2, 8'hA5, 0, 0, 2, 8'hA5, -1, 8'h00, 8'h00, 1'b0));
        vecs.push_back(mk(2'd0, 3'd2, 3'd0, 8'h00, 0, 0, 0, ZERO ? 8'h00 : 8'hA5, 2, 8'hA5, 8'h00, 1'b0));
        vecs.push_back(mk(2'd0, 3'd6, 3'd3, 8'h3C, 4, 0, 3, 8'h3C, -1, 8'h00, 8'h00, 1'b0));
        vecs.push_back(mk(2'd0, 3'd6, 3'd1, 8'h11, 1, 0, 1, 8'h11, -1, 8'h00, 8'h00, 1'b0));
        vecs.push_back(mk(2'd0, 3'd1, 3'd6, 8'h00, 0, 3, 1, 8'h11, -1, 8'h00, 8'h11, 1'b0));
        vecs.push_back(mk(2'd0, 3'd6, 3'd4, 8'h01, 0, 0, 4, 8'h01, -1, 8'h00, 8'h00, 1'b0));
        vecs.push_back(mk(2'd0, 3'd6, 3'd5, 8'hFE, 0, 0, 5, 8'hFE, -1, 8'h00, 8'h00, 1'b0));
        vecs.push_back(mk(2'd1, 3'd4, 3'd5, 8'h00, 0, 0, 4, 8'hFE, 5, 8'h01, 8'h00, 1'b0));
        vecs.push_back(mk(2'd1, 3'd4, 3'd5, 8'h00, 0, 0, 4, 8'h01, 5, 8'hFE, 8'h00, 1'b0));
        vecs.push_back(mk(2'd2, 3'd3, 3'd6, 8'h00, 0, 1, 3, 8'h3C, -1, 8'h00, 8'h00, 1'b0));
        vecs.push_back(mk(2'd0, 3'd6, 3'd6, 8'h5A, 2, 2, 3, 8'h3C, -1, 8'h00, 8'h5A, 1'b0));
        vecs.push_back(mk(2'd2, 3'd0, 3'd3, 8'h00, 0, 0, 3, 8'h00, -1, 8'h00, 8'h00, 1'b0));
        vecs.push_back(mk(2'd1, 3'd2, 3'd2, 8'h00, 0, 0, 2, 8'hA5, -1, 8'h00, 8'h00, 1'b0));
        vecs.push_back(mk(2'd3, 3'd1, 3'd2, 8'h00, 0, 0, 1, 8'h11, 2, 8'hA5, 8'h00, 1'b1));
        vecs.push_back(mk(2'd0, 3'd7, 3'd0, 8'h00, 0, 0, 0, ZERO ? 8'h00 : 8'hA5, -1, 8'h00, 8'h00, 1'b1));
        vecs.push_back(mk(2'd1, 3'd6, 3'd3, 8'h00, 0, 0, 3, 8'h00, -1, 8'h00, 8'h00, 1'b1));
        vecs.push_back(mk(2'd0, 3'd6, 3'd0, 8'h77, 0, 0, 0, ZERO ? 8'h00 : 8'h77, -1, 8'h00, 8'h00, 1'b1));
        vecs.push_back(mk(2'd1, 3'd0, 3'd4, 8'h00, 0, 0, 4, ZERO ? 8'h00 : 8'h77, 0, ZERO ? 8'h00 : 8'h01, 8'h00, 1'b1));

        tick();
        tick();
        rst = 1'b0;
        chk("rst_inst_ready", bus.inst_ready, 1);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_regs", bus.regs_flat, 0);

        foreach (vecs[i]) begin
            exec(vecs[i].op, vecs[i].src, vecs[i].dst, vecs[i].in_val, vecs[i].in_dly, vecs[i].out_dly, got);
            chk($sformatf("vec%0d_reg%0d", i, vecs[i].ia), bus.regs_flat[vecs[i].ia*8 +: 8], vecs[i].va);
            if (vecs[i].ib >= 0)
                chk($sformatf("vec%0d_reg%0d", i, vecs[i].ib), bus.regs_flat[vecs[i].ib*8 +: 8], vecs[i].vb);
            chk($sformatf("vec%0d_err", i), bus.err, vecs[i].exp_err);
            if ((vecs[i].dst == 3'd6) && !is_illegal(vecs[i].op, vecs[i].src, vecs[i].dst))
                chk($sformatf("vec%0d_out", i), got, vecs[i].exp_out);
        end

        // Two register instructions on consecutive edges: no stall between them.
        bus.inst_valid = 1'b1;
        bus.inst       = {2'd0, 3'd2, 3'd5};
        tick();
        chk("b2b_inst_ready", bus.inst_ready, 1);
        bus.inst = {2'd2, 3'd0, 3'd2};
        tick();
        bus.inst_valid = 1'b0;
        model_apply(2'd0, 3'd2, 3'd5, 8'h00, dummy);
        model_apply(2'd2, 3'd0, 3'd2, 8'h00, dummy);
        chk("b2b_regs", bus.regs_flat, model_flat());

        for (int k = 0; k < 200; k++) begin
            r   = int'($urandom_range(0, 19));
            rop = (r < 8) ? 2'd0 : (r < 13) ? 2'd1 : (r < 19) ? 2'd2 : 2'd3;
            exec(rop, 3'($urandom_range(0, (r == 5) ? 7 : 6)), 3'($urandom_range(0, 6)),
                 8'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), got);
        end

        // Reset while waiting for input: the pending write is dropped.
        bus.inst_valid = 1'b1;
        bus.inst       = {2'd0, 3'd6, 3'd2};
        tick();
        bus.inst_valid = 1'b0;
        chk("rstin_in_ready", bus.in_ready, 1);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hEE;
        tick();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        model_reset();
        chk("rstin_busy", bus.busy, 0);
        chk("rstin_in_ready_low", bus.in_ready, 0);
        tick();
        chk("rstin_regs", bus.regs_flat, 0);

        // Reset while output is pending: out_valid and err both clear.
        exec(2'd0, 3'd6, 3'd1, 8'h11, 0, 0, got);
        exec(2'd3, 3'd0, 3'd0, 8'h00, 0, 0, got);
        bus.inst_valid = 1'b1;
        bus.inst       = {2'd0, 3'd1, 3'd6};
        tick();
        bus.inst_valid = 1'b0;
        tick();
        chk("rstout_out_valid_pre", bus.out_valid, 1);
        chk("rstout_out_data_pre", bus.out_data, 8'h11);
        chk("rstout_err_pre", bus.err, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        chk("rstout_out_valid", bus.out_valid, 0);
        chk("rstout_err", bus.err, 0);
        chk("rstout_inst_ready", bus.inst_ready, 1);
        chk("rstout_out_data", bus.out_data, 0);
        exec(2'd0, 3'd6, 3'd3, 8'h3C, 1, 0, got);
        chk("rstout_recover_reg3", bus.regs_flat[3*8 +: 8], 8'h3C);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
